seq_fsm_array: RTL

Parametrised, synthesizable successor to the team's two-flip-flop Mealy controller. It instantiates CH independent copies of the same 2-bit next-state/output logic and adds several features: a selectable active clock edge, a synchronous active-low reset, a per-channel enable, visible state, and a saturating counter of `y` rising events. It sits in the lab datapath wherever the single-channel controller was used, and presents one channel's worth of `a`/`b`/`y`/`z` per bit.

---
 rtl/seq_fsm_array.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seq_fsm_array.sv
// ---------------------------------------------------------------------------
// seq_fsm_array
//
// Array of CH independent two-flop Mealy controllers that share one clock,
// one synchronous active-low reset and one saturating counter of y rising
// events. Each channel keeps a 2-bit state {q1,q2}:
//   IDLE = 00, ACT = 10, TAIL = 01, ILL = 11 (unreachable, self-recovering).
//
// Parameters
//   CH      - number of channels (>= 1)
//   FALLING - 1: every flop updates on the falling clk edge, 0: rising edge
//   CNT_W   - width of the rise-event counter (>= 2)
//
// Ports
//   clk      in   1        single clock, active edge chosen by FALLING
//   rst_n    in   1        synchronous active-low reset, overrides en/cnt_clr
//   en       in   CH       per-channel update enable (low holds the channel)
//   a        in   CH       per-channel input a
//   b        in   CH       per-channel input b
//   cnt_clr  in   1        synchronous clear of rise_cnt
//   y        out  CH       registered output, channel q1
//   z        out  CH       Mealy output, combinational from state and b
//   state    out  2*CH     {q1,q2} of channel i at bits [2i+1:2i]
//   rise_cnt out  CNT_W    saturating count of y 0->1 events, all channels
// ---------------------------------------------------------------------------
module seq_fsm_array #(
   parameter int CH      = 4,
   parameter bit FALLING = 1'b1,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CH-1:0]     en,
   input  logic [CH-1:0]     a,
   input  logic [CH-1:0]     b,
   input  logic              cnt_clr,
   output logic [CH-1:0]     y,
   output logic [CH-1:0]     z,
   output logic [2*CH-1:0]   state,
   output logic [CNT_W-1:0]  rise_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      TAIL = 2'b01,
      ACT  = 2'b10,
      ILL  = 2'b11
   } chan_state_t;

   // The sum must hold the old count plus every channel firing at once, so
   // saturation can be detected instead of silently wrapping.
   localparam int SUM_W = CNT_W + $clog2(CH + 1);
   localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   logic [2*CH-1:0]  state_q;
   logic [2*CH-1:0]  state_d;
   logic [CNT_W-1:0] rise_cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CH-1:0]    rise_vec;
   logic [SUM_W-1:0] ev_sum;
   logic [SUM_W-1:0] cnt_sum;
   chan_state_t      cur_st;
   chan_state_t      nxt_st;
   logic             d1;

   // Per-channel next state, Mealy z and rise-event detection. A disabled
   // channel keeps its state and reports no event, but z still follows b
   // because it is purely combinational from the held state. The rise event
   // is "q1 about to go 0->1", i.e. q1 low while d1 is high.
   always_comb begin
      state_d  = state_q;
      rise_vec = '0;
      z        = '1;
      y        = '0;
      cur_st   = IDLE;
      nxt_st   = IDLE;
      d1       = 1'b0;
      for (int i = 0; i < CH; i++) begin
         cur_st = chan_state_t'(state_q[2*i +: 2]);
         d1     = a[i] | (b[i] & ~cur_st[0]);
         case (cur_st)
            IDLE:    nxt_st = (a[i] | b[i]) ? ACT : IDLE;
            ACT:     nxt_st = (a[i] | b[i]) ? ACT : TAIL;
            TAIL:    nxt_st = a[i] ? ACT : IDLE;
            ILL:     nxt_st = a[i] ? ACT : TAIL;
            default: nxt_st = IDLE;
         endcase
         z[i] = ~cur_st[1] | (b[i] & ~cur_st[0]);
         y[i] = cur_st[1];
         if (en[i]) begin
            state_d[2*i +: 2] = nxt_st;
            rise_vec[i]       = ~cur_st[1] & d1;
         end
      end
   end

   // Counter update: add the population count of this edge's events and
   // clamp at all-ones. A clear wins over any events in the same cycle.
   always_comb begin
      ev_sum = '0;
      for (int i = 0; i < CH; i++) begin
         ev_sum = ev_sum + SUM_W'(rise_vec[i]);
      end
      cnt_sum = SUM_W'(rise_cnt_q) + ev_sum;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (cnt_sum > CNT_MAX) begin
         cnt_d = {CNT_W{1'b1}};
      end else begin
         cnt_d = cnt_sum[CNT_W-1:0];
      end
   end

   // State and counter registers. Only one of the two branches exists after
   // elaboration, so every flop in the block sees a single active edge.
   // Reset returns every channel to IDLE and the counter to zero regardless
   // of en and cnt_clr.
   if (FALLING) begin : g_fall
      always_ff @(negedge clk) begin
         if (!rst_n) begin
            state_q    <= '0;
            rise_cnt_q <= '0;
         end else begin
            state_q    <= state_d;
            rise_cnt_q <= cnt_d;
         end
      end
   end else begin : g_rise
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_q    <= '0;
            rise_cnt_q <= '0;
         end else begin
            state_q    <= state_d;
            rise_cnt_q <= cnt_d;
         end
      end
   end

   assign state    = state_q;
   assign rise_cnt = rise_cnt_q;

endmodule
